// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with a valid/ready handshake.
//
// Sixteen ops: LUI, OR, ADD, SUB, AND, XOR, NOR, SLT, SLTU, SLL, SRL, SRA,
// MULTU, DIVU, MFHI, MFLO. Single-cycle ops register their result on the
// accept edge. MULTU (shift-add) and DIVU (restoring) iterate one bit per
// cycle and then write HI/LO.
//
// Build option: define ALU_SEQ_DIV_EN to build the iterative divider.
// Without it, DIVU is a single-cycle op that returns 0 and leaves HI/LO alone.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operation request
//   in_ready     ALU can accept an op this cycle (IDLE and not in reset)
//   aluop        4-bit operation code
//   SrcA         operand A; SrcA[SHW-1:0] is also the shift amount
//   SrcB         operand B
//   out_valid    one-cycle pulse, alures valid
//   alures       registered result
//   overflow     signed overflow of ADD/SUB, registered with alures
//   div_by_zero  last DIVU had SrcB==0, registered with alures
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    output logic [WIDTH-1:0] alures,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_LUI   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_NOR   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b1001;
    localparam logic [3:0] OP_SRL   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    localparam logic [SHW:0] ITERS = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
`ifdef ALU_SEQ_DIV_EN
        ,
        S_DIV  = 2'd2
`endif
    } state_t;

    state_t state, state_n;

    logic [SHW:0]       cnt;
    logic [2*WIDTH-1:0] prod;   // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opb;    // latched multiplicand / divisor
    logic [WIDTH-1:0]   hi, lo;

    logic               accept;
    logic               multi_op;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ovf;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

    assign in_ready = rst_n && (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign shamt    = SrcA[SHW-1:0];
    assign sum      = SrcA + SrcB;
    assign diff     = SrcA - SrcB;

`ifdef ALU_SEQ_DIV_EN
    assign multi_op = (aluop == OP_MULTU) || (aluop == OP_DIVU);
`else
    assign multi_op = (aluop == OP_MULTU);
`endif

    // Single-cycle result and overflow
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (aluop)
            OP_LUI:  sc_res = SrcB << (WIDTH/2);
            OP_OR:   sc_res = SrcA | SrcB;
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND:  sc_res = SrcA & SrcB;
            OP_XOR:  sc_res = SrcA ^ SrcB;
            OP_NOR:  sc_res = ~(SrcA | SrcB);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_SLL:  sc_res = SrcB << shamt;
            OP_SRL:  sc_res = SrcB >> shamt;
            OP_SRA:  sc_res = $signed(SrcB) >>> shamt;
            OP_MFHI: sc_res = hi;
            OP_MFLO: sc_res = lo;
            default: sc_res = '0;   // MULTU/DIVU here; DIVU returns 0 when the divider is absent
        endcase
    end

    // Shift-add step: conditionally add multiplicand to the upper half, then shift right
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opb};
        mul_step = prod[0] ? {mul_sum, prod[WIDTH-1:1]}
                           : {1'b0, prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]     div_sh, div_diff;
    logic [2*WIDTH-1:0] div_step;

    // Restoring step: remainder < divisor always holds, so bit WIDTH of the
    // trial difference is the borrow.
    always_comb begin
        div_sh   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb};
        div_step = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (aluop == OP_MULTU) state_n = S_MUL;
`ifdef ALU_SEQ_DIV_EN
                    else if (aluop == OP_DIVU) state_n = S_DIV;
`endif
                end
            end
            S_MUL: if (cnt == ITERS) state_n = S_IDLE;
`ifdef ALU_SEQ_DIV_EN
            S_DIV: if (cnt == ITERS) state_n = S_IDLE;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alures      <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            prod        <= '0;
            opb         <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_by_zero <= 1'b0;
                        if (multi_op) begin
                            prod     <= {{WIDTH{1'b0}}, SrcA};
                            opb      <= SrcB;
                            cnt      <= '0;
                            overflow <= 1'b0;
                        end else begin
                            alures    <= sc_res;
                            overflow  <= sc_ovf;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt != ITERS) begin
                        prod <= mul_step;
                        cnt  <= cnt + 1'b1;
                    end else begin
                        hi        <= prod[2*WIDTH-1:WIDTH];
                        lo        <= prod[WIDTH-1:0];
                        alures    <= prod[WIDTH-1:0];
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    if (cnt != ITERS) begin
                        // Zero divisor: count out the same latency but leave the dividend intact
                        if (opb != '0) prod <= div_step;
                        cnt <= cnt + 1'b1;
                    end else begin
                        if (opb == '0) begin
                            hi          <= prod[WIDTH-1:0];
                            lo          <= '1;
                            alures      <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi     <= prod[2*WIDTH-1:WIDTH];
                            lo     <= prod[WIDTH-1:0];
                            alures <= prod[WIDTH-1:0];
                        end
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W = 32;
    localparam logic [3:0] LUI = 4'd0, OR_ = 4'd1, ADD = 4'd2, SUB = 4'd3, SLT = 4'd7,
                           SRA = 4'd11, MULTU = 4'd12, DIVU = 4'd13, MFHI = 4'd14, MFLO = 4'd15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   aluop;
    logic [W-1:0] SrcA, SrcB;
    logic         out_valid;
    logic [W-1:0] alures;
    logic         overflow;
    logic         div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference HI/LO
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
        .alures(alures), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model from the op definitions, using 64-bit arithmetic.
    function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] res, output logic ovf, output logic dbz,
                                   output bit multi);
        longint      sa, sb, s, p, q;
        logic [63:0] ua, ub, u;
        int          sh;
        sa = $signed(a); sb = $signed(b);
        ua = {32'b0, a}; ub = {32'b0, b};
        sh = int'(a[4:0]);
        res = '0; ovf = 1'b0; dbz = 1'b0; multi = 1'b0;
        case (op)
            4'd0:  begin u = ub * 64'd65536; res = u[31:0]; end
            4'd1:  res = a | b;
            4'd2:  begin s = sa + sb; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); res = s[31:0]; end
            4'd3:  begin s = sa - sb; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); res = s[31:0]; end
            4'd4:  res = a & b;
            4'd5:  res = a ^ b;
            4'd6:  res = ~(a | b);
            4'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  res = (ua < ub) ? 32'd1 : 32'd0;
            4'd9:  begin u = ub * (64'd1 << sh); res = u[31:0]; end
            4'd10: begin u = ub / (64'd1 << sh); res = u[31:0]; end
            4'd11: begin
                p = longint'(1) << sh;
                if (sb >= 0) q = sb / p;
                else         q = -((-sb + p - 1) / p);
                res = q[31:0];
            end
            4'd12: begin u = ua * ub; m_hi = u[63:32]; m_lo = u[31:0]; res = m_lo; multi = 1'b1; end
            4'd13: begin
`ifdef ALU_SEQ_DIV_EN
                multi = 1'b1;
                if (b == 0) begin m_lo = '1; m_hi = a; dbz = 1'b1; end
                else begin u = ua / ub; m_lo = u[31:0]; u = ua % ub; m_hi = u[31:0]; end
                res = m_lo;
`else
                res = '0;
`endif
            end
            4'd14: res = m_hi;
            default: res = m_lo;
        endcase
    endfunction

    // Drive one op, hold until accepted, then count edges until out_valid.
    // lat = number of edges after the accept edge; busy_ok clears if in_ready rose early.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic ovf, output logic dbz,
                          output int lat, output bit busy_ok);
        int guard = 0;
        aluop = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        aluop = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
        lat = 0; busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        res = alures; ovf = overflow; dbz = div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; aluop = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else n_pass++;
        n_checks++; if (alures !== '0) $display("FAIL reset_alures: got %h required 0", alures); else n_pass++;
        n_checks++; if ({overflow, div_by_zero} !== 2'b00) $display("FAIL reset_flags: got %b required 00", {overflow, div_by_zero}); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", in_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r; logic o, z; int lat; bit bo;
        run_op(ADD, 32'h7FFFFFFF, 32'h1, r, o, z, lat, bo);
        n_checks++; if (r !== 32'h80000000) $display("FAIL b2b_add: got %h required 80000000", r); else n_pass++;
        n_checks++; if (o !== 1'b1) $display("FAIL b2b_add_ovf: got %b required 1", o); else n_pass++;
        n_checks++; if (lat !== 0) $display("FAIL b2b_add_lat: got %0d required 0", lat); else n_pass++;
        run_op(SLT, 32'hFFFFFFFF, 32'h1, r, o, z, lat, bo);
        n_checks++; if (r !== 32'h1) $display("FAIL b2b_slt: got %h required 1", r); else n_pass++;
        n_checks++; if (o !== 1'b0) $display("FAIL b2b_slt_ovf: got %b required 0", o); else n_pass++;
        n_checks++; if (lat !== 0) $display("FAIL b2b_slt_lat: got %0d required 0", lat); else n_pass++;
        run_op(SRA, 32'h4, 32'h80000000, r, o, z, lat, bo);
        n_checks++; if (r !== 32'hF8000000) $display("FAIL b2b_sra: got %h required f8000000", r); else n_pass++;
        n_checks++; if (lat !== 0) $display("FAIL b2b_sra_lat: got %0d required 0", lat); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL pulse_width: out_valid %b required 0", out_valid); else n_pass++;
    endtask

    task automatic test_lui_or();
        logic [W-1:0] r; logic o, z; int lat; bit bo;
        run_op(LUI, $urandom, 32'h1234, r, o, z, lat, bo);
        n_checks++; if (r !== 32'h12340000) $display("FAIL lui: got %h required 12340000", r); else n_pass++;
        run_op(OR_, 32'h12340000, 32'h5678, r, o, z, lat, bo);
        n_checks++; if (r !== 32'h12345678) $display("FAIL ori: got %h required 12345678", r); else n_pass++;
    endtask

    task automatic test_multu();
        logic [W-1:0] r; logic o, z; int lat; bit bo;
        m_hi = 32'hFFFFFFFE; m_lo = 32'h1;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, o, z, lat, bo);
        n_checks++; if (r !== 32'h1) $display("FAIL multu_lo: got %h required 1", r); else n_pass++;
        n_checks++; if (lat !== W + 1) $display("FAIL multu_lat: got %0d required %0d", lat, W + 1); else n_pass++;
        n_checks++; if (bo !== 1'b1) $display("FAIL multu_busy: in_ready rose before out_valid (ok=%b) required 1", bo); else n_pass++;
        run_op(MFHI, $urandom, $urandom, r, o, z, lat, bo);
        n_checks++; if (r !== 32'hFFFFFFFE) $display("FAIL multu_mfhi: got %h required fffffffe", r); else n_pass++;
        n_checks++; if (lat !== 0) $display("FAIL multu_mfhi_lat: got %0d required 0", lat); else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] r; logic o, z; int lat; bit bo;
        bit saw = 1'b0;
        aluop = MULTU; SrcA = 32'd7; SrcB = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
        rst_n = 1'b0; #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_mid_ready_low: got %b required 0", in_ready); else n_pass++;
        repeat (2) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b required 1", in_ready); else n_pass++;
        repeat (40) begin if (out_valid) saw = 1'b1; @(posedge clk); #1; end
        n_checks++; if (saw !== 1'b0) $display("FAIL rst_mid_no_valid: out_valid seen %b required 0", saw); else n_pass++;
        m_hi = '0; m_lo = '0;
        run_op(MFHI, $urandom, $urandom, r, o, z, lat, bo);
        n_checks++; if (r !== '0) $display("FAIL rst_mid_hi: got %h required 0", r); else n_pass++;
        run_op(MFLO, $urandom, $urandom, r, o, z, lat, bo);
        n_checks++; if (r !== '0) $display("FAIL rst_mid_lo: got %h required 0", r); else n_pass++;
    endtask

`ifdef ALU_SEQ_DIV_EN
    task automatic test_divu();
        logic [W-1:0] r; logic o, z; int lat; bit bo;
        m_hi = 32'd2; m_lo = 32'd14;
        run_op(DIVU, 32'd100, 32'd7, r, o, z, lat, bo);
        n_checks++; if (r !== 32'd14) $display("FAIL divu_q: got %h required e", r); else n_pass++;
        n_checks++; if (lat !== W + 1) $display("FAIL divu_lat: got %0d required %0d", lat, W + 1); else n_pass++;
        n_checks++; if (z !== 1'b0) $display("FAIL divu_dbz: got %b required 0", z); else n_pass++;
        run_op(MFHI, $urandom, $urandom, r, o, z, lat, bo);
        n_checks++; if (r !== 32'd2) $display("FAIL divu_rem: got %h required 2", r); else n_pass++;
        m_hi = 32'd55; m_lo = '1;
        run_op(DIVU, 32'd55, 32'd0, r, o, z, lat, bo);
        n_checks++; if (r !== 32'hFFFFFFFF) $display("FAIL div0_q: got %h required ffffffff", r); else n_pass++;
        n_checks++; if (z !== 1'b1) $display("FAIL div0_flag: got %b required 1", z); else n_pass++;
        n_checks++; if (lat !== W + 1) $display("FAIL div0_lat: got %0d required %0d", lat, W + 1); else n_pass++;
        run_op(MFHI, $urandom, $urandom, r, o, z, lat, bo);
        n_checks++; if (r !== 32'd55) $display("FAIL div0_hi: got %h required 37", r); else n_pass++;
        n_checks++; if (z !== 1'b0) $display("FAIL div0_clear: got %b required 0", z); else n_pass++;
    endtask
`else
    task automatic test_divu_disabled();
        logic [W-1:0] r; logic o, z; int lat; bit bo;
        logic [W-1:0] hi_before;
        hi_before = m_hi;
        run_op(DIVU, 32'd100, 32'd7, r, o, z, lat, bo);
        n_checks++; if (r !== '0) $display("FAIL divoff_res: got %h required 0", r); else n_pass++;
        n_checks++; if (lat !== 0) $display("FAIL divoff_lat: got %0d required 0", lat); else n_pass++;
        n_checks++; if (z !== 1'b0) $display("FAIL divoff_dbz: got %b required 0", z); else n_pass++;
        run_op(MFHI, $urandom, $urandom, r, o, z, lat, bo);
        n_checks++; if (r !== hi_before) $display("FAIL divoff_hi: got %h required %h", r, hi_before); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] r, er; logic o, z, eo, ez; int lat; bit bo, multi;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            if ($urandom_range(0, 3) == 0) b = {1'b0, a[W-2:0]};
            ref_op(op, a, b, er, eo, ez, multi);
            run_op(op, a, b, r, o, z, lat, bo);
            n_checks++; if (r !== er) $display("FAIL rand_res op=%0d a=%h b=%h: got %h required %h", op, a, b, r, er); else n_pass++;
            n_checks++; if (o !== eo) $display("FAIL rand_ovf op=%0d a=%h b=%h: got %b required %b", op, a, b, o, eo); else n_pass++;
            n_checks++; if (z !== ez) $display("FAIL rand_dbz op=%0d: got %b required %b", op, z, ez); else n_pass++;
            n_checks++; if (lat !== (multi ? W + 1 : 0)) $display("FAIL rand_lat op=%0d: got %0d required %0d", op, lat, multi ? W + 1 : 0); else n_pass++;
            n_checks++; if (bo !== 1'b1) $display("FAIL rand_busy op=%0d: in_ready early (ok=%b) required 1", op, bo); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_lui_or();
        test_multu();
        test_reset_mid_mul();
`ifdef ALU_SEQ_DIV_EN
        test_divu();
`else
        test_divu_disabled();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
